fir_stream_ctrl: RTL and testbench

- Valid/ready stream controller that sequences the 8-tap moving-average FIR datapath.
- Accepts input samples under handshake and advances the datapath pipeline one step per accepted sample through a clock-enable (dp_ce).
- Tracks in-flight samples with a token pipeline aligned to the datapath stages, suppresses warm-up (partial-window) outputs, applies output backpressure by stalling the datapath, and drains the pipeline on flush.

---
 rtl/fir_ctrl_pkg.sv | 18 +
 rtl/fir_token_pipe.sv | 26 ++
 rtl/fir_stream_ctrl.sv | 116 +++++++++++
 tb/tb_fir_stream_ctrl.sv | 341 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fir_ctrl_pkg.sv
// Shared types and defaults for the moving-average FIR stream controller.
package fir_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2
   } fir_state_e;

   localparam int TAPS_DEF    = 8;
   localparam int LATENCY_DEF = 5;

   // Bits needed to count 0..taps-1 for the warm-up window counter.
   function automatic int win_cnt_w(input int taps);
      return (taps > 2) ? $clog2(taps) : 1;
   endfunction

endpackage

// File: rtl/fir_token_pipe.sv
// Token shift register tracking which datapath stages hold a result to emit.
module fir_token_pipe
   import fir_ctrl_pkg::*;
#(
   parameter int LATENCY = LATENCY_DEF
) (
   input  logic               CLK,
   input  logic               rst,
   input  logic               ce,
   input  logic               shift_in,
   input  logic               consume,
   output logic [LATENCY-1:0] tok
);

   always_ff @(posedge CLK or negedge rst) begin
      if (!rst) begin
         tok <= '0;
      end else if (ce) begin
         tok <= {tok[LATENCY-2:0], shift_in};
      end else if (consume) begin
         // Result taken while the datapath holds still: retire only the last stage.
         tok[LATENCY-1] <= 1'b0;
      end
   end

endmodule

// File: rtl/fir_stream_ctrl.sv
// Valid/ready sequencer for the moving-average FIR datapath.
//   state    | meaning
//   ST_IDLE  | waiting for start, datapath frozen
//   ST_RUN   | accepting samples, one dp_ce step per accept
//   ST_DRAIN | no input, stepping zeros in until all tokens leave
module fir_stream_ctrl
   import fir_ctrl_pkg::*;
#(
   parameter int DIN_W   = 16,
   parameter int DOUT_W  = 19,
   parameter int TAPS    = TAPS_DEF,
   parameter int LATENCY = LATENCY_DEF,
   parameter int DISCARD = 1,
   parameter int CNT_W   = 16
) (
   input  logic              CLK,
   input  logic              rst,
   input  logic              start,
   input  logic              flush,
   output logic              busy,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DIN_W-1:0]  in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DOUT_W-1:0] out_data,
   output logic              dp_ce,
   output logic [DIN_W-1:0]  dp_din,
   input  logic [DOUT_W-1:0] dp_dout,
   output logic [CNT_W-1:0]  sample_cnt
);

   localparam int               WIN_W   = win_cnt_w(TAPS);
   localparam logic [WIN_W-1:0] WIN_MAX = WIN_W'(TAPS - 1);

   fir_state_e         state_q, state_d;
   logic [WIN_W-1:0]   win_cnt;
   logic [LATENCY-1:0] tok;
   logic               adv, keep, shift_in, consume, clr_cnt, clr_win, cnt_step;

   assign out_valid = tok[LATENCY-1];
   assign out_data  = dp_dout;
   assign adv       = !out_valid || out_ready;
   assign keep      = (DISCARD == 0) || (win_cnt == WIN_MAX);
   assign busy      = (state_q != ST_IDLE);
   assign consume   = out_valid && out_ready && !dp_ce;
   assign cnt_step  = dp_ce && (state_q == ST_RUN);

   always_comb begin
      state_d  = state_q;
      in_ready = 1'b0;
      dp_ce    = 1'b0;
      dp_din   = '0;
      shift_in = 1'b0;
      clr_cnt  = 1'b0;
      clr_win  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d = ST_RUN;
               clr_cnt = 1'b1;
            end
         end
         ST_RUN: begin
            // flush wins over a same-cycle sample
            if (flush) begin
               state_d = ST_DRAIN;
            end else begin
               in_ready = adv;
               if (in_valid && adv) begin
                  dp_ce    = 1'b1;
                  dp_din   = in_data;
                  shift_in = keep;
               end
            end
         end
         ST_DRAIN: begin
            if (tok == '0) begin
               state_d = ST_IDLE;
               clr_win = 1'b1;
            end else if (adv) begin
               dp_ce = 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge rst) begin
      if (!rst) begin
         state_q    <= ST_IDLE;
         win_cnt    <= '0;
         sample_cnt <= '0;
      end else begin
         state_q <= state_d;
         if (clr_cnt) begin
            win_cnt    <= '0;
            sample_cnt <= '0;
         end else if (cnt_step) begin
            sample_cnt <= sample_cnt + CNT_W'(1);
            if (win_cnt != WIN_MAX) win_cnt <= win_cnt + WIN_W'(1);
         end
         if (clr_win) win_cnt <= '0;
      end
   end

   fir_token_pipe #(.LATENCY(LATENCY)) u_tok (
      .CLK      (CLK),
      .rst      (rst),
      .ce       (dp_ce),
      .shift_in (shift_in),
      .consume  (consume),
      .tok      (tok)
   );

endmodule

// File: tb/tb_fir_stream_ctrl.sv
// Bench for fir_stream_ctrl: behavioural 8-tap averaging datapath, scoreboard, vector table.
module tb_fir_stream_ctrl;

   localparam int DIN_W = 16, DOUT_W = 19, TAPS = 8, LATENCY = 5, CNT_W = 16;
   localparam int HIST  = LATENCY - 1 + TAPS;

   logic CLK = 1'b0;
   logic rst = 1'b0;
   always #5 CLK = ~CLK;

   // instance 0: DISCARD=1, instance 1: DISCARD=0
   logic start0 = 0, flush0 = 0, in_valid0 = 0, out_ready0 = 0;
   logic [DIN_W-1:0] in_data0 = '0;
   logic busy0, in_ready0, out_valid0, dp_ce0;
   logic [DOUT_W-1:0] out_data0, dp_dout0, dsum0;
   logic [DIN_W-1:0] dp_din0;
   logic [CNT_W-1:0] sample_cnt0;

   logic start1 = 0, flush1 = 0, in_valid1 = 0, out_ready1 = 0;
   logic [DIN_W-1:0] in_data1 = '0;
   logic busy1, in_ready1, out_valid1, dp_ce1;
   logic [DOUT_W-1:0] out_data1, dp_dout1, dsum1;
   logic [DIN_W-1:0] dp_din1;
   logic [CNT_W-1:0] sample_cnt1;

   fir_stream_ctrl #(.DIN_W(DIN_W), .DOUT_W(DOUT_W), .TAPS(TAPS), .LATENCY(LATENCY),
                     .DISCARD(1), .CNT_W(CNT_W)) u0 (
      .CLK(CLK), .rst(rst), .start(start0), .flush(flush0), .busy(busy0),
      .in_valid(in_valid0), .in_ready(in_ready0), .in_data(in_data0),
      .out_valid(out_valid0), .out_ready(out_ready0), .out_data(out_data0),
      .dp_ce(dp_ce0), .dp_din(dp_din0), .dp_dout(dp_dout0), .sample_cnt(sample_cnt0));

   fir_stream_ctrl #(.DIN_W(DIN_W), .DOUT_W(DOUT_W), .TAPS(TAPS), .LATENCY(LATENCY),
                     .DISCARD(0), .CNT_W(CNT_W)) u1 (
      .CLK(CLK), .rst(rst), .start(start1), .flush(flush1), .busy(busy1),
      .in_valid(in_valid1), .in_ready(in_ready1), .in_data(in_data1),
      .out_valid(out_valid1), .out_ready(out_ready1), .out_data(out_data1),
      .dp_ce(dp_ce1), .dp_din(dp_din1), .dp_dout(dp_dout1), .sample_cnt(sample_cnt1));

   // Datapath model: history of dp_din, output = mean of the window LATENCY-1 steps back.
   logic [DIN_W-1:0] h0 [HIST];
   logic [DIN_W-1:0] h1 [HIST];

   always_ff @(posedge CLK or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < HIST; i++) begin h0[i] <= '0; h1[i] <= '0; end
      end else begin
         if (dp_ce0) begin
            h0[0] <= dp_din0;
            for (int i = 1; i < HIST; i++) h0[i] <= h0[i-1];
         end
         if (dp_ce1) begin
            h1[0] <= dp_din1;
            for (int i = 1; i < HIST; i++) h1[i] <= h1[i-1];
         end
      end
   end

   always_comb begin
      dsum0 = '0;
      dsum1 = '0;
      for (int i = LATENCY - 1; i < HIST; i++) begin
         dsum0 = dsum0 + DOUT_W'(h0[i]);
         dsum1 = dsum1 + DOUT_W'(h1[i]);
      end
   end
   assign dp_dout0 = dsum0 >> $clog2(TAPS);
   assign dp_dout1 = dsum1 >> $clog2(TAPS);

   int errors = 0;
   int checks = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Scoreboard for instance 0
   logic [DIN_W-1:0]  acc_q [$];
   logic [DOUT_W-1:0] exp_q [$];
   int acc_cnt = 0, ce_cnt = 0, out_cnt = 0;

   always @(negedge CLK) begin
      if (!rst) begin
         acc_q.delete();
         exp_q.delete();
      end else begin
         if (start0 && !busy0) acc_q.delete();
         if (in_valid0 && in_ready0) begin
            acc_cnt++;
            acc_q.push_back(in_data0);
            if (acc_q.size() > TAPS) void'(acc_q.pop_front());
            if (acc_q.size() == TAPS) begin
               int s;
               s = 0;
               foreach (acc_q[k]) s += int'(acc_q[k]);
               exp_q.push_back(DOUT_W'(s / TAPS));
            end
         end
         if (dp_ce0) ce_cnt++;
         if (out_valid0 && out_ready0) begin
            out_cnt++;
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL sb_unexpected: got output %0h expected none", out_data0);
            end else begin
               chk("sb_data", 32'(out_data0), 32'(exp_q.pop_front()));
            end
         end
      end
   end

   task automatic cyc();
      @(posedge CLK);
      #1;
   endtask

   task automatic wait_idle(input int maxc, input bit rnd);
      int n;
      for (n = 0; n < maxc; n++) begin
         if (rnd) out_ready0 = 1'($urandom_range(0, 1));
         @(negedge CLK);
         if (!busy0) break;
         @(posedge CLK);
         #1;
      end
      chk("drain_timeout", 32'(n < maxc), 32'(1));
      out_ready0 = 1'b1;
      cyc();
   endtask

   typedef struct packed {
      logic start, flush, iv;
      logic [DIN_W-1:0] din;
      logic ordy;
      logic e_ir, e_ce;
      logic [DIN_W-1:0] e_din;
      logic e_busy, e_ov;
      logic [DOUT_W-1:0] e_dout;
   } vec_t;

   vec_t tbl [11];

   initial begin
      int a0, c0, o0, n;
      logic [DOUT_W-1:0] held;
      logic ov_any;

      // DISCARD=0: samples 8,16, flush with a same-cycle sample, 5 zero drain steps
      tbl[0]  = '{1'b1, 1'b0, 1'b0, 16'd0,  1'b1, 1'b0, 1'b0, 16'd0,  1'b0, 1'b0, 19'd0};
      tbl[1]  = '{1'b0, 1'b0, 1'b1, 16'd8,  1'b1, 1'b1, 1'b1, 16'd8,  1'b1, 1'b0, 19'd0};
      tbl[2]  = '{1'b0, 1'b0, 1'b1, 16'd16, 1'b1, 1'b1, 1'b1, 16'd16, 1'b1, 1'b0, 19'd0};
      tbl[3]  = '{1'b0, 1'b1, 1'b1, 16'd99, 1'b1, 1'b0, 1'b0, 16'd0,  1'b1, 1'b0, 19'd0};
      tbl[4]  = '{1'b0, 1'b0, 1'b0, 16'd0,  1'b1, 1'b0, 1'b1, 16'd0,  1'b1, 1'b0, 19'd0};
      tbl[5]  = '{1'b0, 1'b0, 1'b0, 16'd0,  1'b1, 1'b0, 1'b1, 16'd0,  1'b1, 1'b0, 19'd0};
      tbl[6]  = '{1'b0, 1'b0, 1'b0, 16'd0,  1'b1, 1'b0, 1'b1, 16'd0,  1'b1, 1'b0, 19'd0};
      tbl[7]  = '{1'b0, 1'b0, 1'b0, 16'd0,  1'b1, 1'b0, 1'b1, 16'd0,  1'b1, 1'b1, 19'd1};
      tbl[8]  = '{1'b0, 1'b0, 1'b0, 16'd0,  1'b1, 1'b0, 1'b1, 16'd0,  1'b1, 1'b1, 19'd3};
      tbl[9]  = '{1'b0, 1'b0, 1'b0, 16'd0,  1'b1, 1'b0, 1'b0, 16'd0,  1'b1, 1'b0, 19'd0};
      tbl[10] = '{1'b0, 1'b0, 1'b0, 16'd0,  1'b1, 1'b0, 1'b0, 16'd0,  1'b0, 1'b0, 19'd0};

      repeat (3) @(posedge CLK);
      #1;
      @(negedge CLK);
      chk("rst_busy", 32'(busy0), 32'(0));
      chk("rst_in_ready", 32'(in_ready0), 32'(0));
      chk("rst_out_valid", 32'(out_valid0), 32'(0));
      chk("rst_dp_ce", 32'(dp_ce0), 32'(0));
      chk("rst_sample_cnt", 32'(sample_cnt0), 32'(0));
      @(posedge CLK);
      #1;
      rst = 1'b1;
      cyc();

      for (int r = 0; r < 11; r++) begin
         start1 = tbl[r].start; flush1 = tbl[r].flush; in_valid1 = tbl[r].iv;
         in_data1 = tbl[r].din; out_ready1 = tbl[r].ordy;
         @(negedge CLK);
         chk($sformatf("vec%0d_in_ready", r), 32'(in_ready1), 32'(tbl[r].e_ir));
         chk($sformatf("vec%0d_dp_ce", r), 32'(dp_ce1), 32'(tbl[r].e_ce));
         chk($sformatf("vec%0d_busy", r), 32'(busy1), 32'(tbl[r].e_busy));
         chk($sformatf("vec%0d_out_valid", r), 32'(out_valid1), 32'(tbl[r].e_ov));
         if (tbl[r].e_ce) chk($sformatf("vec%0d_dp_din", r), 32'(dp_din1), 32'(tbl[r].e_din));
         if (tbl[r].e_ov) chk($sformatf("vec%0d_out_data", r), 32'(out_data1), 32'(tbl[r].e_dout));
         cyc();
      end
      chk("d0_sample_cnt", 32'(sample_cnt1), 32'(2));

      // 12 samples of 8, flush: five outputs of 8
      a0 = acc_cnt; c0 = ce_cnt; o0 = out_cnt;
      out_ready0 = 1'b1;
      start0 = 1'b1; cyc(); start0 = 1'b0;
      in_valid0 = 1'b1; in_data0 = 16'd8;
      for (int i = 0; i < 12; i++) begin
         @(negedge CLK);
         if (i == 11) chk("ov_before_12th", 32'(out_valid0), 32'(0));
         cyc();
      end
      in_valid0 = 1'b0; flush0 = 1'b1;
      @(negedge CLK);
      chk("first_ov_after_12th", 32'(out_valid0), 32'(1));
      chk("sample_cnt_12", 32'(sample_cnt0), 32'(12));
      cyc();
      flush0 = 1'b0;
      wait_idle(50, 1'b0);
      chk("run12_outputs", 32'(out_cnt - o0), 32'(5));
      chk("run12_sb_empty", 32'(exp_q.size()), 32'(0));
      chk("run12_ce_steps", 32'(ce_cnt - c0), 32'(12 + LATENCY));
      chk("run12_accepts", 32'(acc_cnt - a0), 32'(12));

      // async reset mid-RUN with 3 tokens in flight
      start0 = 1'b1; cyc(); start0 = 1'b0;
      in_valid0 = 1'b1;
      for (int i = 0; i < 10; i++) begin
         in_data0 = 16'(100 + i);
         cyc();
      end
      in_valid0 = 1'b0;
      @(negedge CLK);
      chk("pre_rst_busy", 32'(busy0), 32'(1));
      chk("pre_rst_cnt", 32'(sample_cnt0), 32'(10));
      #2;
      rst = 1'b0;
      #1;
      chk("async_rst", 32'({out_valid0, busy0, dp_ce0, sample_cnt0}), 32'(0));
      @(negedge CLK);
      @(posedge CLK);
      #1;
      rst = 1'b1;
      ov_any = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(negedge CLK);
         ov_any = ov_any | out_valid0 | busy0;
         cyc();
      end
      chk("post_rst_quiet", 32'(ov_any), 32'(0));

      // backpressure: stall 10 cycles, then full rate
      start0 = 1'b1; cyc(); start0 = 1'b0;
      in_valid0 = 1'b1;
      n = 0;
      for (n = 0; n < 20; n++) begin
         in_data0 = 16'(n * 37 + 5);
         @(negedge CLK);
         if (out_valid0) break;
         cyc();
      end
      chk("bp_fill_timeout", 32'(n < 20), 32'(1));
      cyc();
      out_ready0 = 1'b0;
      in_data0 = 16'h0abc;
      @(negedge CLK);
      held = out_data0;
      cyc();
      for (int i = 0; i < 10; i++) begin
         @(negedge CLK);
         chk($sformatf("stall%0d", i), 32'({in_ready0, dp_ce0, out_valid0, out_data0 == held}),
             32'(4'b0011));
         cyc();
      end
      out_ready0 = 1'b1;
      a0 = acc_cnt;
      for (int i = 0; i < 8; i++) begin
         in_data0 = 16'(1000 + i * 11);
         cyc();
      end
      chk("full_rate", 32'(acc_cnt - a0), 32'(8));
      in_valid0 = 1'b0; flush0 = 1'b1; cyc(); flush0 = 1'b0;
      wait_idle(50, 1'b0);
      chk("bp_sb_empty", 32'(exp_q.size()), 32'(0));

      // start in RUN ignored, flush beats in_valid, start in DRAIN / at DRAIN exit ignored
      start0 = 1'b1; cyc(); start0 = 1'b0;
      in_valid0 = 1'b1;
      for (int i = 0; i < 9; i++) begin
         in_data0 = 16'(7 * i + 3);
         cyc();
      end
      start0 = 1'b1; in_data0 = 16'd77;
      cyc();
      start0 = 1'b0;
      @(negedge CLK);
      chk("start_in_run_ignored", 32'(sample_cnt0), 32'(10));
      flush0 = 1'b1; in_data0 = 16'h5555;
      cyc();
      flush0 = 1'b0; in_valid0 = 1'b0;
      start0 = 1'b1;
      @(negedge CLK);
      chk("flush_rejects_sample", 32'(sample_cnt0), 32'(10));
      chk("drain_busy", 32'(busy0), 32'(1));
      cyc();
      start0 = 1'b0;
      for (n = 0; n < 20; n++) begin
         if (busy0 && !dp_ce0 && !out_valid0) begin
            start0 = 1'b1;
            break;
         end
         cyc();
      end
      chk("drain_exit_found", 32'(n < 20), 32'(1));
      cyc();
      start0 = 1'b0;
      ov_any = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge CLK);
         ov_any = ov_any | busy0;
         cyc();
      end
      chk("start_at_drain_exit_ignored", 32'(ov_any), 32'(0));
      chk("flush_sb_empty", 32'(exp_q.size()), 32'(0));

      // bubbly input with random backpressure
      start0 = 1'b1; cyc(); start0 = 1'b0;
      a0 = acc_cnt; c0 = ce_cnt;
      for (int i = 0; i < 80; i++) begin
         in_valid0 = (i % 2 == 0);
         in_data0 = 16'($urandom_range(0, 65535));
         out_ready0 = 1'($urandom_range(0, 1));
         cyc();
      end
      in_valid0 = 1'b0; flush0 = 1'b1; cyc(); flush0 = 1'b0;
      wait_idle(200, 1'b1);
      chk("bubbly_sb_empty", 32'(exp_q.size()), 32'(0));
      chk("bubbly_ce_steps", 32'(ce_cnt - c0), 32'(acc_cnt - a0 + LATENCY));
      chk("bubbly_sample_cnt", 32'(sample_cnt0), 32'(acc_cnt - a0));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
      $fatal(1, "watchdog");
   end

endmodule
